// File: rtl/ndn_packet_assembler_if.sv
// Byte-stream in / assembled-packet out bundle for ndn_packet_assembler.
// The SPI/FIB side drives through the master modport; the assembler uses slave.
interface ndn_packet_assembler_if #(
  parameter int PREFIX_BYTES = 8,
  parameter int DATA_BYTES   = 32
);
  logic                        RX_valid;
  logic [7:0]                  data_SPI_to_FIB;
  logic                        out_ready;
  logic                        pkt_valid;
  logic                        pkt_is_data;
  logic [7:0]                  pkt_metadata;
  logic [PREFIX_BYTES*8-1:0]   pkt_prefix;
  logic [DATA_BYTES*8-1:0]     pkt_data;
  logic                        frame_error;
  logic                        busy;

  modport master (
    output RX_valid, data_SPI_to_FIB, out_ready,
    input  pkt_valid, pkt_is_data, pkt_metadata, pkt_prefix, pkt_data,
           frame_error, busy
  );

  modport slave (
    input  RX_valid, data_SPI_to_FIB, out_ready,
    output pkt_valid, pkt_is_data, pkt_metadata, pkt_prefix, pkt_data,
           frame_error, busy
  );
endinterface

// File: rtl/ndn_packet_assembler.sv
// Assembles an NDN interest/data packet from a byte stream: metadata byte,
// prefix field, optional payload, then holds it until the consumer takes it.
module ndn_packet_assembler #(
  parameter int PREFIX_BYTES   = 8,
  parameter int DATA_BYTES     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ndn_packet_assembler_if.slave bus
);
  localparam int MAX_BYTES = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW        = PREFIX_BYTES * 8;
  localparam int DW        = DATA_BYTES * 8;
  localparam logic [CNT_W-1:0]  PREFIX_LAST = CNT_W'(PREFIX_BYTES - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST   = CNT_W'(DATA_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_DATA, S_HOLD} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_valid, r_is_data, r_ferr;
  logic [7:0]        r_meta;
  logic [PW-1:0]     r_prefix;
  logic [DW-1:0]     r_data;

  logic w_assembling, w_timeout, w_xfer, w_overrun, w_start;
  logic w_prefix_byte, w_data_byte, w_prefix_last, w_data_last;

  assign w_assembling  = (r_state == S_PREFIX) || (r_state == S_DATA);
  assign w_timeout     = w_assembling && (r_idle == IDLE_LIMIT);
  assign w_xfer        = (r_state == S_HOLD) && bus.out_ready;
  assign w_overrun     = (r_state == S_HOLD) && bus.RX_valid && !bus.out_ready;
  // A byte that coincides with a completed transfer or a timeout opens the next packet.
  assign w_start       = bus.RX_valid && ((r_state == S_IDLE) || w_xfer || w_timeout);
  assign w_prefix_byte = (r_state == S_PREFIX) && bus.RX_valid && !w_timeout;
  assign w_data_byte   = (r_state == S_DATA) && bus.RX_valid && !w_timeout;
  assign w_prefix_last = w_prefix_byte && (r_cnt == PREFIX_LAST);
  assign w_data_last   = w_data_byte && (r_cnt == DATA_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.RX_valid) w_next = S_PREFIX;
      S_PREFIX: begin
        if (w_timeout)          w_next = bus.RX_valid ? S_PREFIX : S_IDLE;
        else if (w_prefix_last) w_next = r_is_data ? S_DATA : S_HOLD;
      end
      S_DATA: begin
        if (w_timeout)        w_next = bus.RX_valid ? S_PREFIX : S_IDLE;
        else if (w_data_last) w_next = S_HOLD;
      end
      S_HOLD:   if (w_xfer) w_next = bus.RX_valid ? S_PREFIX : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Byte and idle counters restart whenever a new phase or packet begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_idle <= '0;
    end else begin
      if ((w_next != r_state) || w_start)     r_cnt <= '0;
      else if (w_prefix_byte || w_data_byte)  r_cnt <= r_cnt + CNT_W'(1);

      if ((w_next != r_state) || w_start || bus.RX_valid) r_idle <= '0;
      else if (w_assembling)                              r_idle <= r_idle + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_is_data <= 1'b0;
      r_ferr    <= 1'b0;
      r_meta    <= '0;
      r_prefix  <= '0;
      r_data    <= '0;
    end else begin
      r_ferr <= w_overrun || w_timeout;

      if ((w_prefix_last && !r_is_data) || w_data_last) r_valid <= 1'b1;
      else if (w_xfer)                                 r_valid <= 1'b0;

      if (w_start) begin
        r_meta    <= bus.data_SPI_to_FIB;
        r_is_data <= bus.data_SPI_to_FIB[7];
        r_prefix  <= '0;
        r_data    <= '0;
      end else begin
        if (w_prefix_byte) r_prefix <= (r_prefix << 8) | PW'(bus.data_SPI_to_FIB);
        if (w_data_byte)   r_data   <= (r_data << 8) | DW'(bus.data_SPI_to_FIB);
      end
    end
  end

  assign bus.pkt_valid    = r_valid;
  assign bus.pkt_is_data  = r_is_data;
  assign bus.pkt_metadata = r_meta;
  assign bus.pkt_prefix   = r_prefix;
  assign bus.pkt_data     = r_data;
  assign bus.frame_error  = r_ferr;
  assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_ndn_packet_assembler.sv
// Directed bench for ndn_packet_assembler: interest, data, backpressure,
// back-to-back, timeout and asynchronous reset scenarios.
module tb_ndn_packet_assembler;
  localparam int PB = 8;
  localparam int DB = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ndn_packet_assembler_if #(.PREFIX_BYTES(PB), .DATA_BYTES(DB)) bus ();

  ndn_packet_assembler #(.PREFIX_BYTES(PB), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] b;
    logic       rdy;
    logic       e_valid;
    logic       e_busy;
    logic       e_ferr;
    logic [7:0] e_meta;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    bus.RX_valid        = v;
    bus.data_SPI_to_FIB = b;
    bus.out_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] exp_d;

  initial begin
    rst                 = 1'b0;
    bus.RX_valid        = 1'b0;
    bus.data_SPI_to_FIB = 8'h00;
    bus.out_ready       = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_valid", bus.pkt_valid, 0);
    chk("rst_is_data", bus.pkt_is_data, 0);
    chk("rst_meta", bus.pkt_metadata, 0);
    chk("rst_prefix", bus.pkt_prefix, 0);
    chk("rst_data", bus.pkt_data, 0);
    chk("rst_ferr", bus.frame_error, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;

    // Interest packet, one byte per cycle, out_ready held high
    tv[0]  = '{1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[3]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[4]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30};
    tv[8]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h30};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30};
    tv[10] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30};
    for (int i = 0; i < 11; i++) begin
      step(tv[i].v, tv[i].b, tv[i].rdy);
      chk($sformatf("int_valid[%0d]", i), bus.pkt_valid, tv[i].e_valid);
      chk($sformatf("int_busy[%0d]", i), bus.busy, tv[i].e_busy);
      chk($sformatf("int_ferr[%0d]", i), bus.frame_error, tv[i].e_ferr);
      chk($sformatf("int_meta[%0d]", i), bus.pkt_metadata, tv[i].e_meta);
      if (i == 8) begin
        chk("int_is_data", bus.pkt_is_data, 0);
        chk("int_prefix", bus.pkt_prefix, 64'h0000FFFF0000FFFF);
        chk("int_data", bus.pkt_data, 0);
      end
    end

    // Data packet, one byte every 3 cycles
    step(1'b1, 8'hB0, 1'b0); step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0); step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0);
    end
    chk("dat_busy_mid", bus.busy, 1);
    exp_d = '0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("dat_valid_pre[%0d]", i), bus.pkt_valid, 0);
      step(1'b1, 8'(i), 1'b0);
      exp_d = (exp_d << 8) | 256'(i);
      if (i != 31) begin step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0); end
    end
    chk("dat_valid", bus.pkt_valid, 1);
    chk("dat_is_data", bus.pkt_is_data, 1);
    chk("dat_meta", bus.pkt_metadata, 8'hB0);
    chk("dat_prefix", bus.pkt_prefix, 64'h0102030405060708);
    chk("dat_data_msb", bus.pkt_data[255:248], 8'h00);
    chk("dat_data_lsb", bus.pkt_data[7:0], 8'h1F);
    chk("dat_data", bus.pkt_data, exp_d);
    step(1'b0, 8'h00, 1'b0);
    chk("dat_valid_hold", bus.pkt_valid, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("dat_valid_drop", bus.pkt_valid, 0);
    chk("dat_busy_drop", bus.busy, 0);

    // Backpressure and overrun
    step(1'b1, 8'h31, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("bp_valid[%0d]", i), bus.pkt_valid, 1);
      chk($sformatf("bp_ferr[%0d]", i), bus.frame_error, 0);
    end
    step(1'b1, 8'hAA, 1'b0);
    chk("ovr_ferr", bus.frame_error, 1);
    chk("ovr_valid", bus.pkt_valid, 1);
    chk("ovr_meta", bus.pkt_metadata, 8'h31);
    chk("ovr_prefix", bus.pkt_prefix, 64'h1112131415161718);
    step(1'b0, 8'h00, 1'b0);
    chk("ovr_ferr_once", bus.frame_error, 0);
    chk("ovr_valid_held", bus.pkt_valid, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("bp_release", bus.pkt_valid, 0);

    // Back-to-back: transfer and next metadata on the same edge
    step(1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0);
    chk("b2b_valid1", bus.pkt_valid, 1);
    step(1'b1, 8'h30, 1'b1);
    chk("b2b_valid_drop", bus.pkt_valid, 0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_meta", bus.pkt_metadata, 8'h30);
    chk("b2b_prefix_clr", bus.pkt_prefix, 0);
    chk("b2b_ferr", bus.frame_error, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
    chk("b2b_valid2", bus.pkt_valid, 1);
    chk("b2b_prefix2", bus.pkt_prefix, 64'h0001020304050607);
    step(1'b0, 8'h00, 1'b1);
    chk("b2b_done", bus.busy, 0);

    // Timeout after metadata plus 3 prefix bytes
    step(1'b1, 8'h40, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("to_valid[%0d]", k), bus.pkt_valid, 0);
      chk($sformatf("to_ferr[%0d]", k), bus.frame_error, (k == 17) ? 1'b1 : 1'b0);
      chk($sformatf("to_busy[%0d]", k), bus.busy, (k <= 16) ? 1'b1 : 1'b0);
    end
    step(1'b1, 8'h20, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b1);
    chk("to_next_valid", bus.pkt_valid, 1);
    chk("to_next_meta", bus.pkt_metadata, 8'h20);
    chk("to_next_prefix", bus.pkt_prefix, 64'h1112131415161718);
    step(1'b0, 8'h00, 1'b1);
    chk("to_next_drop", bus.pkt_valid, 0);

    // Asynchronous reset mid-packet
    step(1'b1, 8'hD0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
    chk("ar_busy_before", bus.busy, 1);
    bus.RX_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", bus.pkt_valid, 0);
    chk("ar_is_data", bus.pkt_is_data, 0);
    chk("ar_meta", bus.pkt_metadata, 0);
    chk("ar_prefix", bus.pkt_prefix, 0);
    chk("ar_data", bus.pkt_data, 0);
    chk("ar_ferr", bus.frame_error, 0);
    chk("ar_busy", bus.busy, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("ar_ferr_after", bus.frame_error, 0);
    chk("ar_busy_after", bus.busy, 0);
    step(1'b1, 8'h33, 1'b0);
    chk("ar_accept_busy", bus.busy, 1);
    chk("ar_accept_meta", bus.pkt_metadata, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
